// File: rtl/rv32i_alu_imm_unit_if.sv
// Execute-stage operand/result bundle between the ID/EX register, the ALU/immediate unit and its consumers.
// The master drives the instruction and operands; the slave (the ALU unit) returns the results.
interface rv32i_alu_imm_unit_if;
    logic [31:0] inst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] imm;
    logic [31:0] result;
    logic        take_b;
    logic [31:0] result_q;
    logic        take_b_q;

    modport master (
        output inst, in_a, in_b,
        input  imm, result, take_b, result_q, take_b_q
    );

    modport slave (
        input  inst, in_a, in_b,
        output imm, result, take_b, result_q, take_b_q
    );
endinterface

// File: rtl/rv32i_alu_imm_unit.sv
// RV32I execute-stage datapath: combinational ALU, branch comparator and immediate decoder,
// with an optional one-cycle registered copy of the ALU outputs.
module rv32i_alu_imm_unit #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    rv32i_alu_imm_unit_if.slave   bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] i;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7_alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;

    assign i      = bus.inst;
    assign opcode = i[6:0];
    assign funct3 = i[14:12];
    assign f7_alt = i[30];
    assign a      = bus.in_a;
    assign b      = bus.in_b;
    assign shamt  = b[4:0];
    assign lt_s   = $signed(a) < $signed(b);
    assign lt_u   = a < b;
    assign eq     = a == b;

    // Immediate decoder
    always_comb begin
        bus.imm = 32'h0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                bus.imm = {{21{i[31]}}, i[30:20]};
            OP_STORE:
                bus.imm = {{21{i[31]}}, i[30:25], i[11:7]};
            OP_BRANCH:
                bus.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                bus.imm = {i[31:12], 12'b0};
            OP_JAL:
                bus.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default:
                bus.imm = 32'h0;
        endcase
    end

    // ALU: only register and immediate arithmetic decode funct3; everything else is an address add
    always_comb begin
        bus.result = a + b;
        if (opcode == OP_REG || opcode == OP_IMM) begin
            case (funct3)
                3'b000:  bus.result = (opcode == OP_REG && f7_alt) ? (a - b) : (a + b);
                3'b001:  bus.result = a << shamt;
                3'b010:  bus.result = {31'b0, lt_s};
                3'b011:  bus.result = {31'b0, lt_u};
                3'b100:  bus.result = a ^ b;
                3'b101:  bus.result = f7_alt ? 32'($signed(a) >>> shamt) : (a >> shamt);
                3'b110:  bus.result = a | b;
                3'b111:  bus.result = a & b;
                default: bus.result = a + b;
            endcase
        end
    end

    // Branch condition
    always_comb begin
        bus.take_b = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000:  bus.take_b = eq;
                3'b001:  bus.take_b = !eq;
                3'b100:  bus.take_b = lt_s;
                3'b101:  bus.take_b = !lt_s;
                3'b110:  bus.take_b = lt_u;
                3'b111:  bus.take_b = !lt_u;
                default: bus.take_b = 1'b0;
            endcase
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [31:0] result_r;
            logic        take_b_r;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    result_r <= 32'h0;
                    take_b_r <= 1'b0;
                end else begin
                    result_r <= bus.result;
                    take_b_r <= bus.take_b;
                end
            end

            assign bus.result_q = result_r;
            assign bus.take_b_q = take_b_r;
        end else begin : g_no_reg_out
            assign bus.result_q = 32'h0;
            assign bus.take_b_q = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_rv32i_alu_imm_unit.sv
// Directed bench for rv32i_alu_imm_unit: ALU ops, branch conditions, immediate formats and output registers.
module tb_rv32i_alu_imm_unit;
    logic clk;
    logic resetn;
    int   n_assert;
    int   n_fail;

    rv32i_alu_imm_unit_if bus ();

    rv32i_alu_imm_unit #(.REG_OUT(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
        bus.inst = inst;
        bus.in_a = a;
        bus.in_b = b;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        @(negedge clk);
        drive(32'h0020_80B3, 32'h5, 32'h7);
        tick();
        check("rst_result_q", bus.result_q, 32'h0);
        check("rst_take_b_q", {31'b0, bus.take_b_q}, 32'h0);

        // R-type add/sub
        drive(32'h4020_80B3, 32'h5, 32'h7);
        check("sub", bus.result, 32'hFFFF_FFFE);
        check("r_imm_zero", bus.imm, 32'h0);
        drive(32'h0020_80B3, 32'h5, 32'h7);
        check("add", bus.result, 32'd12);

        // ADDI with inst[30] set must still add
        drive(32'hC000_8093, 32'd10, 32'hFFFF_FC00);
        check("addi_imm", bus.imm, 32'hFFFF_FC00);
        check("addi_neg", bus.result, 32'hFFFF_FC0A);

        // Shifts use only in_b[4:0]
        drive(32'h4040_D093, 32'h8000_0000, 32'h4000_0404);
        check("srai", bus.result, 32'hF800_0000);
        drive(32'h0040_D093, 32'h8000_0000, 32'h4000_0404);
        check("srli", bus.result, 32'h0800_0000);
        drive(32'h4020_D0B3, 32'hF000_00F0, 32'h0000_0024);
        check("sra_r", bus.result, 32'hFF00_000F);
        drive(32'h0020_90B3, 32'h1, 32'hFFFF_FFE5);
        check("sll", bus.result, 32'h20);

        // Compares and logic
        drive(32'h0020_A0B3, 32'hFFFF_FFFF, 32'h1);
        check("slt", bus.result, 32'h1);
        drive(32'h0020_B0B3, 32'hFFFF_FFFF, 32'h1);
        check("sltu", bus.result, 32'h0);
        drive(32'h0020_C0B3, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("xor", bus.result, 32'hFF00_EDCB);
        drive(32'h0020_E0B3, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("or", bus.result, 32'hFFF0_FFFF);
        drive(32'h0020_F0B3, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("and", bus.result, 32'h00F0_1234);

        // Non-ALU opcodes take the add path regardless of funct3
        drive(32'h0000_006F, 32'h100, 32'h4);
        check("jal_add", bus.result, 32'h104);
        check("jal_imm", bus.imm, 32'h0);
        drive(32'h0000_A003, 32'h1000, 32'h10);
        check("load_add", bus.result, 32'h1010);

        // Branch conditions
        drive(32'h0020_C063, 32'hFFFF_FFFF, 32'h1);
        check("blt", {31'b0, bus.take_b}, 32'h1);
        drive(32'h0020_E063, 32'hFFFF_FFFF, 32'h1);
        check("bltu", {31'b0, bus.take_b}, 32'h0);
        drive(32'h0020_F063, 32'hFFFF_FFFF, 32'h1);
        check("bgeu", {31'b0, bus.take_b}, 32'h1);
        drive(32'h0020_D063, 32'hFFFF_FFFF, 32'h1);
        check("bge", {31'b0, bus.take_b}, 32'h0);
        drive(32'h0020_9063, 32'h3, 32'h3);
        check("bne", {31'b0, bus.take_b}, 32'h0);
        drive(32'h0020_A063, 32'h3, 32'h3);
        check("b_f3_010", {31'b0, bus.take_b}, 32'h0);
        drive(32'h0020_80B3, 32'h3, 32'h3);
        check("add_no_branch", {31'b0, bus.take_b}, 32'h0);
        drive(32'h0020_8063, 32'h3, 32'h3);
        check("beq", {31'b0, bus.take_b}, 32'h1);
        tick();
        check("take_b_q", {31'b0, bus.take_b_q}, 32'h0);

        // Immediate formats
        drive(32'hFE00_0EE3, 32'h0, 32'h0);
        check("imm_b_i7set", bus.imm, 32'hFFFF_FFFC);
        drive(32'hFE00_0E63, 32'h0, 32'h0);
        check("imm_b_i7clr", bus.imm, 32'hFFFF_F7FC);
        drive(32'h0000_006F, 32'h0, 32'h0);
        check("imm_j_zero", bus.imm, 32'h0);
        drive(32'h8000_00EF, 32'h0, 32'h0);
        check("imm_j_neg", bus.imm, 32'hFFF0_0000);
        drive(32'h1234_5037, 32'h0, 32'h0);
        check("imm_lui", bus.imm, 32'h1234_5000);
        drive(32'hFE11_2E23, 32'h0, 32'h0);
        check("imm_sw", bus.imm, 32'hFFFF_FFFC);

        // Registered outputs: beq taken is registered while out of reset
        resetn = 1'b1;
        drive(32'h0020_8063, 32'h3, 32'h3);
        tick();
        check("take_b_q_set", {31'b0, bus.take_b_q}, 32'h1);

        // Reset wins over data, combinational path unaffected
        drive(32'h0020_80B3, 32'h1000, 32'h0234);
        resetn = 1'b0;
        tick();
        check("rst_hold_q", bus.result_q, 32'h0);
        check("rst_hold_tb_q", {31'b0, bus.take_b_q}, 32'h0);
        check("rst_comb", bus.result, 32'h1234);
        resetn = 1'b1;
        tick();
        check("release_q", bus.result_q, 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
